// File: rtl/approx_add_pipe_if.sv
// Operand/result stream bundle for approx_add_pipe: valid/ready on both sides.
interface approx_add_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic [WIDTH:0]   out_err;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_sum, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_sum, out_err
  );
endinterface

// File: rtl/approx_add_pipe.sv
// Pipelined WIDTH-bit approximate adder (exact/LOA/truncate/copy) with error statistics.
// Latency 2 cycles, 1 beat/cycle.
// Backpressure: a stage advances only into an empty or draining stage; in_ready is combinational from out_ready.
module approx_add_pipe #(
  parameter int WIDTH = 8,
  parameter int K     = 4,
  parameter int ACC_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  approx_add_pipe_if.slave   io,
  input  logic               stats_clr,
  output logic [WIDTH:0]     err_max,
  output logic [ACC_W-1:0]   err_sum,
  output logic [ACC_W-1:0]   n_samples
);
  localparam int KC = (K > 0) ? K - 1 : 0;
  localparam int SW = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;
  localparam logic [WIDTH:0] LO_MASK = {(WIDTH + 1){1'b1}} >> (WIDTH + 1 - K);
  localparam logic [SW-1:0]  ACC_MAX = {{(SW - ACC_W){1'b0}}, {ACC_W{1'b1}}};

  logic [1:0]       rst_sync;
  logic             s1_full, s2_full;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [1:0]       s1_mode;
  logic [WIDTH:0]   s2_sum, s2_err;
  logic             in_fire, s2_adv, out_fire;

  // Release of rst_n takes effect only after two clean edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign io.in_ready  = rst_sync[1] && (!s1_full || !s2_full || io.out_ready);
  assign in_fire      = io.in_valid && io.in_ready;
  assign s2_adv       = s1_full && (!s2_full || io.out_ready);
  assign out_fire     = s2_full && io.out_ready;
  assign io.out_valid = s2_full;
  assign io.out_sum   = s2_sum;
  assign io.out_err   = s2_err;

  logic [WIDTH:0] a_ext, b_ext, exact, approx, hi_sum, lo_bits, err;
  logic           cin;

  always_comb begin
    a_ext   = {1'b0, s1_a};
    b_ext   = {1'b0, s1_b};
    exact   = a_ext + b_ext;
    cin     = 1'b0;
    lo_bits = '0;
    case (s1_mode)
      2'b01: begin
        lo_bits = (a_ext | b_ext) & LO_MASK;
        cin     = (K > 0) && s1_a[KC] && s1_b[KC];
      end
      2'b11:   lo_bits = a_ext & LO_MASK;
      default: lo_bits = '0;
    endcase
    // Upper part is a plain add of the bits above K; with K=WIDTH it reduces to cin.
    hi_sum = (a_ext >> K) + (b_ext >> K) + {{WIDTH{1'b0}}, cin};
    approx = (s1_mode == 2'b00) ? exact : ((hi_sum << K) | lo_bits);
    err    = (exact >= approx) ? exact - approx : approx - exact;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_mode <= '0;
      s2_full <= 1'b0;
      s2_sum  <= '0;
      s2_err  <= '0;
    end else begin
      if (in_fire) begin
        s1_full <= 1'b1;
        s1_a    <= io.in_a;
        s1_b    <= io.in_b;
        s1_mode <= io.in_mode;
      end else if (s2_adv) begin
        s1_full <= 1'b0;
      end
      if (s2_adv) begin
        s2_full <= 1'b1;
        s2_sum  <= approx;
        s2_err  <= err;
      end else if (out_fire) begin
        s2_full <= 1'b0;
      end
    end
  end

  logic [SW-1:0] sum_next, cnt_next;

  // A clear coinciding with a handshake restarts the statistics from this beat.
  always_comb begin
    sum_next = (stats_clr ? '0 : SW'(err_sum)) + SW'(s2_err);
    cnt_next = (stats_clr ? '0 : SW'(n_samples)) + SW'(1);
    if (sum_next > ACC_MAX) sum_next = ACC_MAX;
    if (cnt_next > ACC_MAX) cnt_next = ACC_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_max   <= '0;
      err_sum   <= '0;
      n_samples <= '0;
    end else if (out_fire) begin
      err_max   <= (stats_clr || s2_err > err_max) ? s2_err : err_max;
      err_sum   <= sum_next[ACC_W-1:0];
      n_samples <= cnt_next[ACC_W-1:0];
    end else if (stats_clr) begin
      err_max   <= '0;
      err_sum   <= '0;
      n_samples <= '0;
    end
  end
endmodule

// File: tb/tb_approx_add_pipe.sv
// Bench for approx_add_pipe: arithmetic reference model + scoreboard, directed vectors.
module tb_approx_add_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        clr0, clr1;
  logic [8:0]  emax0, emax1;
  logic [23:0] esum0, nsmp0;
  logic [3:0]  esum1, nsmp1;

  approx_add_pipe_if #(.WIDTH(8)) io0 ();
  approx_add_pipe_if #(.WIDTH(8)) io1 ();

  approx_add_pipe #(.WIDTH(8), .K(4), .ACC_W(24)) u_dut (
    .clk(clk), .rst_n(rst_n), .io(io0.slave), .stats_clr(clr0),
    .err_max(emax0), .err_sum(esum0), .n_samples(nsmp0)
  );

  approx_add_pipe #(.WIDTH(8), .K(8), .ACC_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .io(io1.slave), .stats_clr(clr1),
    .err_max(emax1), .err_sum(esum1), .n_samples(nsmp1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: {approx_sum, |exact-approx|} from the mode rules in plain integer arithmetic.
  function automatic logic [17:0] model(input int a, input int b, input int m, input int k);
    int p, ex, hi, c, ap, er;
    p  = 1 << k;
    ex = a + b;
    hi = (a / p) + (b / p);
    c  = (k > 0) ? (((a >> (k - 1)) & 1) & ((b >> (k - 1)) & 1)) : 0;
    case (m)
      0:       ap = ex;
      1:       ap = (hi + c) * p + ((a | b) % p);
      2:       ap = hi * p;
      default: ap = hi * p + (a % p);
    endcase
    er = (ex > ap) ? ex - ap : ap - ex;
    return {9'(ap), 9'(er)};
  endfunction

  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic [8:0]  emax_m[2];
  int          esum_m[2];
  int          n_m[2];
  bit          stall_p[2];
  logic [8:0]  sum_p[2];
  logic [8:0]  err_p[2];

  task automatic lane_step(input int l, input bit rn, input bit iv, input bit ir,
                           input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                           input bit ov, input bit orr, input logic [8:0] sum, input logic [8:0] err,
                           input bit clr, input logic [8:0] emax, input logic [23:0] esum,
                           input logic [23:0] nsmp, input int k, input int accw);
    logic [17:0] e;
    int mx;
    bit have;
    mx = (1 << accw) - 1;
    if (!rn) begin
      if (l == 0) q0.delete(); else q1.delete();
      emax_m[l] = '0; esum_m[l] = 0; n_m[l] = 0; stall_p[l] = 1'b0;
      check($sformatf("L%0d rst_out_valid", l), ov, 0);
      check($sformatf("L%0d rst_n_samples", l), nsmp, 0);
      return;
    end
    check($sformatf("L%0d err_max", l), emax, emax_m[l]);
    check($sformatf("L%0d err_sum", l), esum, esum_m[l]);
    check($sformatf("L%0d n_samples", l), nsmp, n_m[l]);
    if (stall_p[l]) begin
      check($sformatf("L%0d stall_valid", l), ov, 1);
      check($sformatf("L%0d stall_sum", l), sum, sum_p[l]);
      check($sformatf("L%0d stall_err", l), err, err_p[l]);
    end
    if (ov && orr) begin
      have = (l == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (!have) begin
        tests++; fails++;
        $display("FAIL L%0d unexpected_out: got sum %0h expected no beat", l, sum);
      end else begin
        e = (l == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("L%0d out_sum", l), sum, e[17:9]);
        check($sformatf("L%0d out_err", l), err, e[8:0]);
        emax_m[l] = (clr || e[8:0] > emax_m[l]) ? e[8:0] : emax_m[l];
        esum_m[l] = (clr ? 0 : esum_m[l]) + int'(e[8:0]);
        if (esum_m[l] > mx) esum_m[l] = mx;
        n_m[l] = (clr ? 0 : n_m[l]) + 1;
        if (n_m[l] > mx) n_m[l] = mx;
      end
    end else if (clr) begin
      emax_m[l] = '0; esum_m[l] = 0; n_m[l] = 0;
    end
    if (iv && ir) begin
      e = model(int'(a), int'(b), int'(m), k);
      if (l == 0) q0.push_back(e); else q1.push_back(e);
    end
    stall_p[l] = ov && !orr;
    sum_p[l]   = sum;
    err_p[l]   = err;
  endtask

  always @(negedge clk) begin
    lane_step(0, rst_n, io0.in_valid, io0.in_ready, io0.in_a, io0.in_b, io0.in_mode,
              io0.out_valid, io0.out_ready, io0.out_sum, io0.out_err, clr0,
              emax0, esum0, nsmp0, 4, 24);
    lane_step(1, rst_n, io1.in_valid, io1.in_ready, io1.in_a, io1.in_b, io1.in_mode,
              io1.out_valid, io1.out_ready, io1.out_sum, io1.out_err, clr1,
              emax1, 24'(esum1), 24'(nsmp1), 8, 4);
  end

  // Single beat on lane 0 with out_ready high; checks latency and literal result.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                      input logic [8:0] es, input logic [8:0] ee, input bit clr_out);
    int cyc;
    io0.in_a = a; io0.in_b = b; io0.in_mode = m; io0.in_valid = 1'b1;
    cyc = 0;
    while (!io0.in_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check($sformatf("accept_%0h_%0h", a, b), io0.in_ready, 1);
    @(posedge clk); #1;
    io0.in_valid = 1'b0;
    cyc = 0;
    while (!io0.out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check($sformatf("latency_%0h_%0h", a, b), cyc, 1);
    check($sformatf("sum_%0h_%0h_m%0d", a, b, m), io0.out_sum, es);
    check($sformatf("err_%0h_%0h_m%0d", a, b, m), io0.out_err, ee);
    clr0 = clr_out;
    @(posedge clk); #1;
    clr0 = 1'b0;
  endtask

  logic [7:0] bpa[4] = '{8'h12, 8'h9C, 8'h77, 8'hF1};
  logic [7:0] bpb[4] = '{8'h34, 8'h64, 8'h88, 8'h0E};
  logic [1:0] bpm[4] = '{2'd0, 2'd1, 2'd2, 2'd3};

  initial begin
    int idx, run, guard;
    rst_n = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    io0.in_valid = 1'b0; io0.in_a = '0; io0.in_b = '0; io0.in_mode = '0; io0.out_ready = 1'b1;
    io1.in_valid = 1'b0; io1.in_a = '0; io1.in_b = '0; io1.in_mode = '0; io1.out_ready = 1'b1;

    check("model_k0_loa", model(8'h0F, 8'h01, 1, 0), {9'h010, 9'h000});
    check("model_k8_loa", model(8'hC0, 8'h80, 1, 8), {9'h1C0, 9'h080});
    check("model_trunc",  model(8'h37, 8'h29, 2, 4), {9'h050, 9'h010});

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", io0.out_valid, 0);
    check("rst_out_sum", io0.out_sum, 0);
    check("rst_out_err", io0.out_err, 0);
    check("rst_err_max", emax0, 0);
    check("rst_err_sum", esum0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("sync_in_ready_low", io0.in_ready, 0);
    @(posedge clk); #1;
    check("in_ready_after_rst", io0.in_ready, 1);

    send(8'hFF, 8'h01, 2'd0, 9'h100, 9'h000, 1'b0);
    send(8'h0F, 8'h01, 2'd1, 9'h00F, 9'h001, 1'b0);
    send(8'h37, 8'h29, 2'd2, 9'h050, 9'h010, 1'b0);
    send(8'h0A, 8'h05, 2'd3, 9'h00A, 9'h005, 1'b0);
    check("stats4_err_max", emax0, 9'h010);
    check("stats4_err_sum", esum0, 24'd22);
    check("stats4_n", nsmp0, 24'd4);

    send(8'h08, 8'h08, 2'd1, 9'h018, 9'h008, 1'b1);
    check("clr_hs_n", nsmp0, 24'd1);
    check("clr_hs_sum", esum0, 24'd8);
    check("clr_hs_max", emax0, 9'h008);
    clr0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0;
    check("clr_only_n", nsmp0, 0);
    check("clr_only_max", emax0, 0);

    // Backpressure: downstream stalled for 6 cycles while 4 beats are offered.
    io0.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      io0.in_valid = 1'b1;
      io0.in_a = bpa[idx]; io0.in_b = bpb[idx]; io0.in_mode = bpm[idx];
      @(negedge clk);
      if (io0.in_ready) idx++;
      @(posedge clk); #1;
    end
    check("bp_accepted", idx, 2);
    check("bp_in_ready", io0.in_ready, 0);
    io0.out_ready = 1'b1;
    run = 0;
    for (int c = 0; c < 4; c++) begin
      io0.in_valid = (idx < 4);
      if (idx < 4) begin io0.in_a = bpa[idx]; io0.in_b = bpb[idx]; io0.in_mode = bpm[idx]; end
      @(negedge clk);
      if (io0.in_valid && io0.in_ready) idx++;
      if (io0.out_valid) run++;
      @(posedge clk); #1;
    end
    io0.in_valid = 1'b0;
    check("bp_all_accepted", idx, 4);
    check("bp_no_gaps", run, 4);
    repeat (3) @(posedge clk);
    #1;
    check("bp_drained", io0.out_valid, 0);

    // Saturating counters on the ACC_W=4, K=WIDTH instance.
    idx = 0; guard = 0;
    while (idx < 20 && guard < 60) begin
      io1.in_valid = 1'b1;
      io1.in_a = 8'(idx * 13); io1.in_b = 8'(idx * 7 + 128); io1.in_mode = 2'(idx);
      @(negedge clk);
      if (io1.in_ready) idx++;
      @(posedge clk); #1;
      guard++;
    end
    io1.in_valid = 1'b0;
    check("sat_fed", idx, 20);
    repeat (4) @(posedge clk);
    #1;
    check("sat_n_samples", nsmp1, 4'hF);
    check("sat_err_sum", esum1, 4'hF);

    // Reset with two beats in flight.
    io0.out_ready = 1'b0;
    io0.in_valid = 1'b1; io0.in_a = 8'h21; io0.in_b = 8'h43; io0.in_mode = 2'd1;
    @(posedge clk); #1;
    io0.in_a = 8'h55; io0.in_b = 8'h66; io0.in_mode = 2'd2;
    @(posedge clk); #1;
    io0.in_valid = 1'b0;
    check("pre_rst_valid", io0.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_drops_valid", io0.out_valid, 0);
    check("rst_clears_n", nsmp0, 0);
    check("rst_clears_max", emax0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    io0.out_ready = 1'b1;
    run = 0;
    repeat (8) begin
      @(negedge clk);
      if (io0.out_valid) run++;
    end
    check("nothing_after_rst", run, 0);
    check("stats_after_rst", nsmp0, 0);
    check("queues_drained", q0.size() + q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end
endmodule
